// File: rtl/vga_timing.sv
// vga_timing: VGA raster timing generator with a one-pixel-latency registered colour/sync output stage.
module vga_timing #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] r_in,
    input  logic [3:0] g_in,
    input  logic [3:0] b_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       pix_en,
    output logic       visible,
    output logic       frame_start,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs
);
    localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_LO  = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_HI  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_LO  = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_HI  = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [9:0] X_VIS  = 10'(H_VIS);
    localparam logic [9:0] Y_VIS  = 10'(V_VIS);

    logic        pix_en_q, pix_en_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hs_q, hs_d, vs_q, vs_d;

    // Everything advances only on pixel-enable edges, so X/Y are stable for two clocks.
    always_comb begin
        pix_en_d = ~pix_en_q;
        x_d      = pix_en_q ? ((x_q == H_LAST) ? 10'd0 : x_q + 10'd1) : x_q;
        y_d      = (pix_en_q && x_q == H_LAST) ? ((y_q == V_LAST) ? 10'd0 : y_q + 10'd1) : y_q;
        rgb_d    = pix_en_q ? (visible ? {r_in, g_in, b_in} : 12'h000) : rgb_q;
        hs_d     = pix_en_q ? !(x_q >= HS_LO && x_q <= HS_HI) : hs_q;
        vs_d     = pix_en_q ? !(y_q >= VS_LO && y_q <= VS_HI) : vs_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_en_q <= 1'b0;
            x_q      <= 10'd0;
            y_q      <= 10'd0;
            rgb_q    <= 12'h000;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
        end else begin
            pix_en_q <= pix_en_d;
            x_q      <= x_d;
            y_q      <= y_d;
            rgb_q    <= rgb_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign pix_en      = pix_en_q;
    assign visible     = (x_q < X_VIS) && (y_q < Y_VIS);
    assign frame_start = pix_en_q && x_q == 10'd0 && y_q == 10'd0;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed checks of a full-size raster line plus whole frames of a shrunken raster.
module tb_vga_timing;
    logic       clk = 1'b0, rst = 1'b1, rst_s = 1'b1;
    logic [3:0] r_in = 4'h0, g_in = 4'h0, b_in = 4'hF;
    logic [9:0] x, y, x_s, y_s;
    logic       pix_en, visible, frame_start, vga_hs, vga_vs;
    logic       pix_en_s, visible_s, frame_start_s, vga_hs_s, vga_vs_s;
    logic [3:0] vga_r, vga_g, vga_b, vga_r_s, vga_g_s, vga_b_s;
    logic [3:0] r_drv;
    int n_chk = 0, n_fail = 0;
    int p, xp, yp, ex, ey, sxp, syp;
    bit vis, svis;
    int hs_low = 0, hs_first = -1, vs_low_s = 0, fs_cnt_s = 0, fs_last_s = -1;

    vga_timing dut (
        .clk(clk), .rst(rst), .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .x(x), .y(y), .pix_en(pix_en), .visible(visible), .frame_start(frame_start),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs)
    );

    // 16x8 raster: HS low at x 10..12, VS low at y 5..6, frame = 256 clocks
    vga_timing #(.H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                 .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_s (
        .clk(clk), .rst(rst_s), .r_in(4'hF), .g_in(4'h0), .b_in(4'hF),
        .x(x_s), .y(y_s), .pix_en(pix_en_s), .visible(visible_s), .frame_start(frame_start_s),
        .vga_r(vga_r_s), .vga_g(vga_g_s), .vga_b(vga_b_s), .vga_hs(vga_hs_s), .vga_vs(vga_vs_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) step();
        chk("rst_pix_en", 32'(pix_en), 32'd0);
        chk("rst_x", 32'(x), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_vga_b", 32'(vga_b), 32'd0);
        chk("rst_hs", 32'(vga_hs), 32'd1);
        chk("rst_vs", 32'(vga_vs), 32'd1);
        rst = 1'b0;
        rst_s = 1'b0;
        chk("pre_edge_pix_en", 32'(pix_en), 32'd0);
        chk("pre_edge_frame_start", 32'(frame_start), 32'd0);
        for (int c = 1; c <= 2200; c++) begin
            step();
            ex = (c / 2) % 800;
            ey = (c / 1600) % 525;
            p = (c - 2) / 2;
            xp = p % 800;
            yp = (p / 800) % 525;
            vis = (c >= 2) && xp < 640 && yp < 480;
            r_drv = 4'(xp);
            chk("x", 32'(x), 32'(ex));
            chk("y", 32'(y), 32'(ey));
            chk("pix_en", 32'(pix_en), 32'(c % 2));
            chk("visible", 32'(visible), 32'(ex < 640 && ey < 480));
            chk("frame_start", 32'(frame_start), 32'(c == 1));
            chk("vga_r", 32'(vga_r), vis ? 32'(r_drv) : 32'd0);
            chk("vga_g", 32'(vga_g), 32'd0);
            chk("vga_b", 32'(vga_b), vis ? 32'hF : 32'd0);
            chk("hs", 32'(vga_hs), 32'((c < 2) || !(xp >= 656 && xp <= 751)));
            if (!vga_hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = c;
            end
            sxp = p % 16;
            syp = (p / 16) % 8;
            svis = (c >= 2) && sxp < 8 && syp < 4;
            chk("s_x", 32'(x_s), 32'((c / 2) % 16));
            chk("s_y", 32'(y_s), 32'((c / 32) % 8));
            chk("s_frame_start", 32'(frame_start_s), 32'(c % 256 == 1));
            chk("s_vga_r", 32'(vga_r_s), svis ? 32'hF : 32'd0);
            chk("s_hs", 32'(vga_hs_s), 32'((c < 2) || !(sxp >= 10 && sxp <= 12)));
            chk("s_vs", 32'(vga_vs_s), 32'((c < 2) || !(syp >= 5 && syp <= 6)));
            if (!vga_vs_s) vs_low_s++;
            if (frame_start_s) begin
                if (fs_last_s >= 0) chk("s_frame_period", 32'(c - fs_last_s), 32'd256);
                fs_last_s = c;
                fs_cnt_s++;
            end
            r_in = 4'(ex);
        end
        chk("hs_low_clocks", 32'(hs_low), 32'd192);
        chk("hs_first_low", 32'(hs_first), 32'd1314);
        chk("s_vs_low_clocks", 32'(vs_low_s), 32'd512);
        chk("s_frame_count", 32'(fs_cnt_s), 32'd9);
        // Mid-line reset at x=300, y=1: must take effect before the next edge
        #2;
        rst = 1'b1;
        #1;
        chk("async_pix_en", 32'(pix_en), 32'd0);
        chk("async_x", 32'(x), 32'd0);
        chk("async_y", 32'(y), 32'd0);
        chk("async_vga_r", 32'(vga_r), 32'd0);
        chk("async_vga_b", 32'(vga_b), 32'd0);
        chk("async_hs", 32'(vga_hs), 32'd1);
        chk("async_vs", 32'(vga_vs), 32'd1);
        repeat (3) step();
        rst = 1'b0;
        r_in = 4'hF;
        chk("restart_x0", 32'(x), 32'd0);
        step();
        chk("restart_pix_en", 32'(pix_en), 32'd1);
        chk("restart_x_hold", 32'(x), 32'd0);
        chk("restart_frame_start", 32'(frame_start), 32'd1);
        step();
        chk("restart_x1", 32'(x), 32'd1);
        chk("restart_y0", 32'(y), 32'd0);
        chk("restart_vga_r", 32'(vga_r), 32'hF);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
